// File: rtl/adder_sched.sv
// adder_sched: round-robin scheduler that sequences OPW-bit adds through one shared
// WIDTH-bit adder slice, LSB chunk first, with the carry held between chunks.
module adder_sched #(
    parameter int WIDTH = 8,
    parameter int CHUNKS = 4,
    parameter int NREQ = 4,
    parameter int ID_W = 2,
    localparam int OPW = WIDTH * CHUNKS,
    localparam int K_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_a,
    input  logic [NREQ*OPW-1:0] req_b,
    input  logic [NREQ-1:0]     req_cin,
    output logic [WIDTH-1:0]    add_a,
    output logic [WIDTH-1:0]    add_b,
    output logic                add_cin,
    input  logic [WIDTH-1:0]    add_sum,
    input  logic                add_cout,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ID_W-1:0]     res_id,
    output logic [OPW-1:0]      res_sum,
    output logic                res_cout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt;
    logic found;
    logic [K_W-1:0] k;
    logic carry;
    logic [OPW-1:0] op_a;
    logic [OPW-1:0] op_b;
    // first valid requester at or after ptr, wrapping modulo NREQ
    always_comb begin
        found = 1'b0;
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[(int'(ptr) + i) % NREQ]) begin
                found = 1'b1;
                gnt = ID_W'((int'(ptr) + i) % NREQ);
            end
        end
    end
    assign req_ready = (Reset_n && state == IDLE && found) ? NREQ'(1) << gnt : '0;
    assign add_a = (state == RUN) ? op_a[int'(k)*WIDTH +: WIDTH] : '0;
    assign add_b = (state == RUN) ? op_b[int'(k)*WIDTH +: WIDTH] : '0;
    assign add_cin = (state == RUN) && carry;
    assign res_valid = (state == DONE);
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            ptr <= '0;
            k <= '0;
            carry <= 1'b0;
            op_a <= '0;
            op_b <= '0;
            res_id <= '0;
            res_sum <= '0;
            res_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    op_a <= req_a[int'(gnt)*OPW +: OPW];
                    op_b <= req_b[int'(gnt)*OPW +: OPW];
                    carry <= req_cin[gnt];
                    res_id <= gnt;
                    k <= '0;
                    ptr <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    res_sum[int'(k)*WIDTH +: WIDTH] <= add_sum;
                    carry <= add_cout;
                    k <= k + 1'b1;
                    if (int'(k) == CHUNKS - 1) begin
                        res_cout <= add_cout;
                        k <= '0;
                        state <= DONE;
                    end
                end
                DONE: if (res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_sched.sv
// tb_adder_sched: randomized and directed checks of adder_sched against an arithmetic
// reference; the shared adder slice is modelled beside the scheduler.
module tb_adder_sched;
    localparam int WIDTH = 8, CHUNKS = 4, NREQ = 4, ID_W = 2, OPW = WIDTH * CHUNKS;
    logic Clk_tb = 1'b0;
    logic Reset_n = 1'b0;
    logic [NREQ-1:0] req_valid = '0, req_ready, req_cin = '0;
    logic [NREQ*OPW-1:0] req_a = '0, req_b = '0;
    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic add_cin, add_cout;
    logic res_valid, res_ready = 1'b1, res_cout;
    logic [ID_W-1:0] res_id;
    logic [OPW-1:0] res_sum;
    int n_tests = 0, n_fail = 0;
    int exp_ptr = 0;

    adder_sched #(.WIDTH(WIDTH), .CHUNKS(CHUNKS), .NREQ(NREQ), .ID_W(ID_W)) dut (
        .Clk(Clk_tb), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_sum(res_sum), .res_cout(res_cout)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    always #5 Clk_tb = ~Clk_tb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_grant(input logic [NREQ-1:0] v, input int p);
        for (int i = 0; i < NREQ; i++)
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        return 0;
    endfunction

    function automatic logic [63:0] full_sum(input int id);
        return {32'b0, req_a[id*OPW +: OPW]} + {32'b0, req_b[id*OPW +: OPW]} + 64'(req_cin[id]);
    endfunction

    task automatic run_op(input int id, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                          input logic cin, input int stall);
        logic [63:0] full, m, cexp, held_sum;
        int w;
        full = {32'b0, a} + {32'b0, b} + 64'(cin);
        @(negedge Clk_tb);
        req_a[id*OPW +: OPW] = a;
        req_b[id*OPW +: OPW] = b;
        req_cin[id] = cin;
        req_valid[id] = 1'b1;
        res_ready = (stall == 0);
        #1;
        w = 0;
        while (req_ready == '0 && w < 50) begin
            @(negedge Clk_tb);
            #1;
            w++;
        end
        check("grant", req_ready, NREQ'(1) << exp_grant(req_valid, exp_ptr));
        exp_ptr = (id + 1) % NREQ;
        @(negedge Clk_tb);
        req_valid[id] = 1'b0;
        for (int c = 0; c < CHUNKS; c++) begin
            m = (64'd1 << (WIDTH * c)) - 1;
            cexp = (({32'b0, a} & m) + ({32'b0, b} & m) + 64'(cin)) >> (WIDTH * c);
            check("run_add_a", add_a, WIDTH'(a >> (WIDTH * c)));
            check("run_add_b", add_b, WIDTH'(b >> (WIDTH * c)));
            check("run_add_cin", add_cin, cexp[0]);
            check("run_no_valid", res_valid, 0);
            check("run_no_ready", req_ready, 0);
            @(negedge Clk_tb);
        end
        check("res_valid", res_valid, 1);
        check("res_sum", res_sum, full[OPW-1:0]);
        check("res_cout", res_cout, full[OPW]);
        check("res_id", res_id, id);
        check("idle_slice", {add_a, add_b, add_cin}, 0);
        held_sum = {31'b0, res_cout, res_sum};
        for (int s = 0; s < stall; s++) begin
            @(negedge Clk_tb);
            req_valid = '1;
            #1;
            check("bp_valid", res_valid, 1);
            check("bp_sum", {31'b0, res_cout, res_sum}, held_sum);
            check("bp_id", res_id, id);
            check("bp_ready", req_ready, 0);
        end
        req_valid = '0;
        res_ready = 1'b1;
        @(negedge Clk_tb);
        check("consumed", res_valid, 0);
    endtask

    initial begin
        int grants, last, g, w;
        logic [63:0] fs;
        res_ready = 1'b1;
        repeat (2) @(negedge Clk_tb);
        req_valid = '1;
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_valid", res_valid, 0);
        check("rst_res", {res_id, res_cout, res_sum}, 0);
        check("rst_slice", {add_a, add_b, add_cin}, 0);
        req_valid = '0;
        @(negedge Clk_tb);
        Reset_n = 1'b1;
        exp_ptr = 0;

        run_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
        run_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(3, 32'h0000_0000, 32'h0000_0000, 1'b1, 0);
        run_op(2, $urandom, $urandom, 1'($urandom_range(0, 1)), 5);
        for (int n = 0; n < 20; n++)
            run_op($urandom_range(0, NREQ - 1), (n % 5 == 0) ? 32'hFFFF_FFFF : $urandom, $urandom,
                   1'($urandom_range(0, 1)), $urandom_range(0, 2));

        // round-robin with every requester held valid from reset
        @(negedge Clk_tb);
        Reset_n = 1'b0;
        exp_ptr = 0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*OPW +: OPW] = $urandom;
            req_b[i*OPW +: OPW] = $urandom;
            req_cin[i] = 1'($urandom_range(0, 1));
        end
        @(negedge Clk_tb);
        req_valid = '1;
        res_ready = 1'b1;
        Reset_n = 1'b1;
        grants = 0;
        last = 0;
        for (int cyc = 0; cyc < 100 && grants < 5; cyc++) begin
            #1;
            check("rr_onehot", $onehot0(req_ready), 1);
            if (req_ready != '0) begin
                g = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                check("rr_order", g, exp_grant(req_valid, exp_ptr));
                check("rr_seq", g, grants % NREQ);
                if (grants > 0) check("rr_gap", cyc - last, CHUNKS + 2);
                exp_ptr = (g + 1) % NREQ;
                last = cyc;
                grants++;
            end
            if (res_valid) begin
                fs = full_sum(int'(res_id));
                check("rr_sum", {31'b0, res_cout, res_sum}, fs[OPW:0]);
            end
            @(negedge Clk_tb);
        end
        check("rr_grants", grants, 5);
        req_valid = '0;
        w = 0;
        while (!res_valid && w < 20) begin
            @(negedge Clk_tb);
            w++;
        end
        fs = full_sum(0);
        check("rr_last", {29'b0, res_id, res_cout, res_sum}, {29'b0, 2'd0, fs[OPW:0]});
        @(negedge Clk_tb);

        // reset in the middle of chunk 2 of an operation from requester 2
        req_a[2*OPW +: OPW] = $urandom;
        req_b[2*OPW +: OPW] = $urandom;
        req_valid[2] = 1'b1;
        #1;
        w = 0;
        while (!req_ready[2] && w < 20) begin
            @(negedge Clk_tb);
            #1;
            w++;
        end
        check("mid_grant", req_ready, 4'b0100);
        exp_ptr = 3;
        @(negedge Clk_tb);
        req_valid = '0;
        repeat (2) @(negedge Clk_tb);
        Reset_n = 1'b0;
        req_valid = '1;
        exp_ptr = 0;
        #1;
        check("mid_ready", req_ready, 0);
        check("mid_valid", res_valid, 0);
        check("mid_res", {res_id, res_cout, res_sum}, 0);
        check("mid_slice", {add_a, add_b, add_cin}, 0);
        @(negedge Clk_tb);
        req_valid = '0;
        Reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("post_rst_quiet", res_valid, 0);
            @(negedge Clk_tb);
        end
        req_valid = '1;
        #1;
        check("post_rst_grant", req_ready, NREQ'(1) << exp_grant(req_valid, exp_ptr));
        req_valid = '0;
        repeat (2) @(negedge Clk_tb);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/adder_sched.md
# adder_sched

Round-robin scheduler that shares one combinational `adder` slice between `NREQ` requesters and sequences wide additions through it.
- Each accepted request is a `WIDTH*CHUNKS`-bit add, executed LSB-chunk first over `CHUNKS` consecutive cycles.
- Carry is held in a register between chunks.
- The scheduler instantiates nothing itself. It drives the slice's `a`/`b`/`c_in` and consumes `sum`/`c_out`; the slice is instantiated beside it in the same parent.

## Interface
Parameters:
- `WIDTH`, default 8: adder slice width.
- `CHUNKS`, default 4: slices per operation. Operand width is `OPW = WIDTH*CHUNKS` (32).
- `NREQ`, default 4: number of requesters.
- `ID_W`, default 2: requester-index width; must satisfy `2**ID_W >= NREQ`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `Clk`, input, 1: rising-edge clock.
  - `Reset_n`, input, 1: asynchronous active-low reset.
- Request side:
  - `req_valid`, input, `NREQ`: request pending, one bit per requester.
  - `req_ready`, output, `NREQ`: one-hot grant and accept.
  - `req_a`, input, `NREQ*OPW`: operand A, requester i at `[i*OPW +: OPW]`.
  - `req_b`, input, `NREQ*OPW`: operand B, same packing as `req_a`.
  - `req_cin`, input, `NREQ`: carry-in per requester.
- Adder-slice side:
  - `add_a`, output, `WIDTH`: slice operand A.
  - `add_b`, output, `WIDTH`: slice operand B.
  - `add_cin`, output, 1: slice carry-in.
  - `add_sum`, input, `WIDTH`: slice sum, combinational from the `add_*` outputs.
  - `add_cout`, input, 1: slice carry-out.
- Result side:
  - `res_valid`, output, 1: result available.
  - `res_ready`, input, 1: consumer accepts the result.
  - `res_id`, output, `ID_W`: index of the requester that owns the result.
  - `res_sum`, output, `OPW`: full sum.
  - `res_cout`, output, 1: final carry-out.

## Operation
States: `IDLE`, `RUN`, `DONE`. Reset state is `IDLE`.

- **IDLE**
  - Grant goes to the first `req_valid` bit found searching from `ptr` upward, modulo `NREQ`.
  - `req_ready` is asserted combinationally on the granted bit only. It is all-zero if no request is valid, and all-zero in `RUN` and `DONE`.
  - On the accept edge, the scheduler:
    - latches A, B and cin of the granted requester;
    - sets `res_id` to the grant index;
    - sets `carry = req_cin[g]` and chunk count `k = 0`;
    - sets `ptr = (g+1) mod NREQ`;
    - moves to `RUN`.
- **RUN**
  - Slice drive:
    - `add_a` = A chunk k (`[k*WIDTH +: WIDTH]`);
    - `add_b` = B chunk k;
    - `add_cin = carry`.
  - Each edge:
    - `res_sum[k*WIDTH +: WIDTH] <= add_sum`;
    - `carry <= add_cout`;
    - `k <= k+1`.
  - On the edge with `k == CHUNKS-1`: `res_cout <= add_cout` and move to `DONE`.
- **DONE**
  - `res_valid = 1`.
  - `res_sum`, `res_cout` and `res_id` are held stable until `res_valid && res_ready` at an edge, then the state returns to `IDLE`.
- **Slice inputs outside RUN:** `add_a`, `add_b` and `add_cin` are driven to 0 in `IDLE` and `DONE`.
- **Arithmetic:** `res_sum` and `res_cout` equal the `OPW+1`-bit value `A + B + cin`. Overflow wraps modulo `2**OPW`, with the carry reported in `res_cout`.
- **Requester contract:** a requester holds `req_valid` and its operands stable until it sees `req_ready`. The scheduler does not check this.
- **Arbitration fairness:** a requester that stays valid waits for at most `NREQ-1` other operations.
- **Reset:** `Reset_n` low at any time, including mid-`RUN` or in `DONE`, takes effect immediately (asynchronously):
  - state = `IDLE`, `ptr` = 0, `k` = 0, `carry` = 0;
  - all outputs = 0;
  - any in-flight operation is discarded and never produces `res_valid`.

## Timing
- **Accept edge T:** the edge at which `req_valid[g]` and `req_ready[g]` are both high.
- **Result:** chunks are captured at edges T+1 … T+CHUNKS, and `res_valid` rises after edge T+CHUNKS. Latency is `CHUNKS` cycles.
- **Back-to-back throughput:** with `res_ready` tied high, the result is consumed at edge T+CHUNKS+1. The earliest next accept is edge T+CHUNKS+2, so one operation completes every `CHUNKS+2` cycles.
- **No combinational path** from `res_ready` to any output. `req_ready` depends combinationally only on `req_valid`, `ptr` and state.
- **Simultaneous events:** a `req_valid` arriving during `RUN`/`DONE` waits in `IDLE`. A request dropped before grant is simply not served.

## Test plan
- **Chunk carry:** req0 with A=0x0000_00FF, B=0x0000_0001, cin=0 → `res_sum`=0x0000_0100, `res_cout`=0, `res_id`=0, `res_valid` exactly 4 cycles after accept.
- **Full wrap:** req1 with A=0xFFFF_FFFF, B=0x0000_0001, cin=0 → `res_sum`=0x0000_0000, `res_cout`=1, `res_id`=1.
- **Carry-in only:** req3 with A=0, B=0, cin=1 → `res_sum`=0x0000_0001, `res_cout`=0. During each `RUN` cycle, check `add_a`/`add_b` against the expected chunk k.
- **Round-robin:** all four `req_valid` held high from reset with `res_ready`=1 → grant order 0,1,2,3,0. Consecutive accepts are 6 cycles apart; `req_ready` is never multi-hot.
- **Backpressure:** `res_ready`=0 for 5 cycles after `res_valid` → `res_sum`, `res_cout` and `res_id` stay stable; `req_ready` stays 0 throughout; exactly one result is consumed when `res_ready` rises.
- **Reset mid-operation:** `Reset_n` pulsed low during `RUN` chunk 2 → all outputs are 0 immediately. After release, no `res_valid` appears until a new accept, and the next grant goes to requester 0.
